systolic_feeder: RTL and testbench

- Upstream stage of the INT4×FP16 systolic array; drives the array's west (activation) and north (weight) edges.
- Buffers one K-deep tile of N-lane FP16 activation beats and N-lane unsigned INT4 weight beats.
- On start, streams the tile with diagonal skew: lane i is delayed i cycles, so the wavefront enters the array aligned.
- Non-valid edge slots are driven with zeros, so a PE multiply yields 0.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/skew_delay.sv | 42 ++++
 rtl/systolic_feeder.sv | 186 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared widths, FSM encoding and lane helpers for the INT4xFP16 systolic array slice
// (feeder, pe and array top).
package systolic_pkg;

    localparam int ACT_W = 16;
    localparam int WGT_W = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LOADED = 2'd1,
        STREAM = 2'd2
    } feeder_state_e;

    // One edge slot: activation, weight and its valid flag.
    function automatic int slot_bits(input int act_w, input int wgt_w);
        return act_w + wgt_w + 1;
    endfunction

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Per-lane delay line of DEPTH cycles with zero fill; DEPTH=0 is a plain wire.
module skew_delay #(
    parameter int DEPTH = 0,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ rst_n;
            assign d_out = d_in;
        end else begin : g_shift
            logic [W-1:0] pipe_q [DEPTH];
            logic [W-1:0] pipe_d [DEPTH];

            always_comb begin
                pipe_d[0] = d_in;
                for (int s = 1; s < DEPTH; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < DEPTH; s++) begin
                        pipe_q[s] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign d_out = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Tile buffer and diagonally skewed west/north edge driver for the systolic array.
// Optional SYSTOLIC_FEEDER_PERF_CNT_EN adds the perf_cycles stream-length counter.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N                = 4,
    parameter int ACTIVATION_WIDTH = ACT_W,
    parameter int WEIGHT_WIDTH     = WGT_W,
    parameter int K_MAX            = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*ACTIVATION_WIDTH-1:0] in_act,
    input  logic [N*WEIGHT_WIDTH-1:0]     in_wgt,
    input  logic                          in_last,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [N*ACTIVATION_WIDTH-1:0] act_out,
    output logic [N*WEIGHT_WIDTH-1:0]     wgt_out,
    output feeder_state_e                 dbg_state,
    output logic [N-1:0]                  lane_valid
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_cycles
`endif
);

    localparam int AW     = ACTIVATION_WIDTH;
    localparam int WW     = WEIGHT_WIDTH;
    localparam int CNT_W  = $clog2(K_MAX + 1);
    localparam int T_W    = $clog2(K_MAX + N);
    localparam int IDX_W  = idx_bits(K_MAX);
    localparam int SLOT_W = slot_bits(AW, WW);

    feeder_state_e state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, k_q, k_d;
    logic [T_W-1:0]   t_q, t_d;
    logic             in_ready_q, in_ready_d;
    logic             fin_q, fin_d, done_q, done_d;
    logic [N*AW-1:0]  act_out_q, act_out_d;
    logic [N*WW-1:0]  wgt_out_q, wgt_out_d;
    logic [N-1:0]     lane_valid_q, lane_valid_d;
    logic             wr_en, row_valid;
    logic [N*AW-1:0]  skew_act;
    logic [N*WW-1:0]  skew_wgt;
    logic [N-1:0]     skew_vld;

    logic [N*AW-1:0]  act_mem_q [K_MAX];
    logic [N*WW-1:0]  wgt_mem_q [K_MAX];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            act_mem_q[count_q[IDX_W-1:0]] <= in_act;
            wgt_mem_q[count_q[IDX_W-1:0]] <= in_wgt;
        end
    end

    // Row t of the tile enters every lane at once; the lane delay lines add the skew.
    assign row_valid = (state_q == STREAM) && (t_q < T_W'(k_q));

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [SLOT_W-1:0] slot_in, slot_out;
        assign slot_in = row_valid ? {1'b1, act_mem_q[t_q[IDX_W-1:0]][i*AW +: AW],
                                      wgt_mem_q[t_q[IDX_W-1:0]][i*WW +: WW]} : '0;
        skew_delay #(.DEPTH(i), .W(SLOT_W)) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .d_in  (slot_in),
            .d_out (slot_out)
        );
        assign skew_vld[i]          = slot_out[SLOT_W-1];
        assign skew_act[i*AW +: AW] = slot_out[WW +: AW];
        assign skew_wgt[i*WW +: WW] = slot_out[WW-1:0];
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        k_d          = k_q;
        t_d          = t_q;
        wr_en        = 1'b0;
        fin_d        = 1'b0;
        done_d       = fin_q;
        act_out_d    = '0;
        wgt_out_d    = '0;
        lane_valid_d = '0;
        case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (in_last || (count_q == CNT_W'(K_MAX - 1))) begin
                        k_d     = count_q + CNT_W'(1);
                        state_d = LOADED;
                    end
                end
            end
            LOADED: begin
                if (start) begin
                    t_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                act_out_d    = skew_act;
                wgt_out_d    = skew_wgt;
                lane_valid_d = skew_vld;
                t_d          = t_q + T_W'(1);
                if (t_q == T_W'(k_q) + T_W'(N - 2)) begin
                    state_d = LOAD;
                    count_d = '0;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD) && (count_d < CNT_W'(K_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            count_q      <= '0;
            k_q          <= '0;
            t_q          <= '0;
            in_ready_q   <= 1'b0;
            fin_q        <= 1'b0;
            done_q       <= 1'b0;
            act_out_q    <= '0;
            wgt_out_q    <= '0;
            lane_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            k_q          <= k_d;
            t_q          <= t_d;
            in_ready_q   <= in_ready_d;
            fin_q        <= fin_d;
            done_q       <= done_d;
            act_out_q    <= act_out_d;
            wgt_out_q    <= wgt_out_d;
            lane_valid_q <= lane_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = (state_q == STREAM);
    assign done       = done_q;
    assign act_out    = act_out_q;
    assign wgt_out    = wgt_out_q;
    assign lane_valid = lane_valid_q;
    assign dbg_state  = state_q;

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        perf_run_q, perf_run_d;

    always_comb begin
        perf_d     = perf_q;
        perf_run_d = perf_run_q;
        if ((state_q == LOADED) && start) begin
            perf_d     = '0;
            perf_run_d = 1'b1;
        end else if (perf_run_q) begin
            if (perf_q != '1) perf_d = perf_q + 32'd1;
            if (done_q) perf_run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q     <= '0;
            perf_run_q <= 1'b0;
        end else begin
            perf_q     <= perf_d;
            perf_run_q <= perf_run_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: vector table, random tiles against an
// index-based edge model, and hand sequences for the multi-cycle corners.
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int WW    = 4;
    localparam int K_MAX = 16;

    typedef struct {
        int pat;       // 0: 3C00/4000/4200 ramp, 1: all 3C00/F, 2: random
        int n_drive;   // beats presented with in_valid
        bit use_last;
        int exp_k;     // beats kept in the tile
        int exp_win;   // output cycles before done
    } vec_t;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_last  = 1'b0;
    logic            start    = 1'b0;
    logic [N*AW-1:0] in_act   = '0;
    logic [N*WW-1:0] in_wgt   = '0;
    logic            in_ready, busy, done;
    logic [N*AW-1:0] act_out;
    logic [N*WW-1:0] wgt_out;
    logic [N-1:0]    lane_valid;
    feeder_state_e   dbg_state;
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    logic [31:0]     perf_cycles;
`endif

    logic [N*AW-1:0] t_act [K_MAX];
    logic [N*WW-1:0] t_wgt [K_MAX];
    vec_t            vecs [6];
    int n_checks = 0;
    int n_errors = 0;
    int exp_perf = 0;

    systolic_feeder #(.N(N), .ACTIVATION_WIDTH(AW), .WEIGHT_WIDTH(WW), .K_MAX(K_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_wgt     (in_wgt),
        .in_last    (in_last),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .act_out    (act_out),
        .wgt_out    (wgt_out),
        .dbg_state  (dbg_state),
        .lane_valid (lane_valid)
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] out_word();
        return 128'({act_out, wgt_out, lane_valid, done, busy});
    endfunction

    // Edge contents c cycles into the output window: lane i carries beat c-i.
    function automatic logic [127:0] model_word(input int c, input int k, input int win);
        logic [N*AW-1:0] ea;
        logic [N*WW-1:0] ew;
        logic [N-1:0]    ev;
        logic            d, b;
        ea = '0;
        ew = '0;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = c - i;
            if (j >= 0 && j < k) begin
                ea[i*AW +: AW] = t_act[j][i*AW +: AW];
                ew[i*WW +: WW] = t_wgt[j][i*WW +: WW];
                ev[i]          = 1'b1;
            end
        end
        d = (c == win);
        b = (c < win - 1);
        return 128'({ea, ew, ev, d, b});
    endfunction

    // driver tasks
    task automatic fill_tile(input int pat);
        logic [AW-1:0] ramp [3];
        ramp[0] = 16'h3C00;
        ramp[1] = 16'h4000;
        ramp[2] = 16'h4200;
        for (int b = 0; b < K_MAX; b++) begin
            for (int i = 0; i < N; i++) begin
                case (pat)
                    0: begin
                        t_act[b][i*AW +: AW] = ramp[b % 3];
                        t_wgt[b][i*WW +: WW] = WW'(b % 3 + 1);
                    end
                    1: begin
                        t_act[b][i*AW +: AW] = 16'h3C00;
                        t_wgt[b][i*WW +: WW] = 4'hF;
                    end
                    default: begin
                        t_act[b][i*AW +: AW] = AW'($urandom);
                        t_wgt[b][i*WW +: WW] = WW'($urandom_range(0, 15));
                    end
                endcase
            end
        end
    endtask

    task automatic load_tile(input int n_drive, input bit use_last, input int exp_k,
                             input bit start_on_last, input string tag);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, ".ready_wait"}, 128'(in_ready), 128'(1));
        for (int b = 0; b < n_drive; b++) begin
            in_valid = 1'b1;
            in_act   = t_act[b % K_MAX];
            in_wgt   = t_wgt[b % K_MAX];
            in_last  = use_last && (b == n_drive - 1);
            start    = start_on_last && (b == n_drive - 1);
            check($sformatf("%s.in_ready%0d", tag, b), 128'(in_ready), 128'(b < exp_k));
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        check({tag, ".loaded"}, 128'({in_ready, busy, dbg_state}), 128'({1'b0, 1'b0, LOADED}));
    endtask

    // scoreboard: expected edge words for the whole window, then done, then idle
    task automatic stream_tile(input int k, input int win, input string tag);
        logic [127:0] exp_q[$];
        for (int c = 0; c <= win; c++) exp_q.push_back(model_word(c, k, win));
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
        check({tag, ".perf_hold"}, 128'(perf_cycles), 128'(exp_perf));
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".started"}, 128'({busy, in_ready}), 128'(2'b10));
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
        check({tag, ".perf_clear"}, 128'(perf_cycles), 128'(0));
`endif
        for (int c = 0; c <= win; c++) begin
            tick();
            check($sformatf("%s.c%0d", tag, c), out_word(), exp_q.pop_front());
        end
        tick();
        check({tag, ".idle"}, out_word(), 128'(0));
        exp_perf = win + 2;
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
        check({tag, ".perf_total"}, 128'(perf_cycles), 128'(exp_perf));
`endif
    endtask

    initial begin
        int  k, n_drive, exp_k;
        bit  use_last;
        logic seen_done;

        vecs[0] = '{0, 3, 1'b1, 3, 6};
        vecs[1] = '{2, 17, 1'b0, 16, 19};
        vecs[2] = '{1, 1, 1'b1, 1, 4};
        vecs[3] = '{2, 5, 1'b1, 5, 8};
        vecs[4] = '{2, 16, 1'b1, 16, 19};
        vecs[5] = '{2, 9, 1'b1, 9, 12};

        #1 rst_n = 1'b0;
        #2;
        check("reset.outs", out_word(), 128'(0));
        check("reset.ready_state", 128'({in_ready, dbg_state}), 128'({1'b0, LOAD}));
        #9 rst_n = 1'b1;
        tick();
        check("reset.release", 128'({in_ready, dbg_state}), 128'({1'b1, LOAD}));

        for (int v = 0; v < 6; v++) begin
            fill_tile(vecs[v].pat);
            load_tile(vecs[v].n_drive, vecs[v].use_last, vecs[v].exp_k, 1'b0, $sformatf("vec%0d", v));
            stream_tile(vecs[v].exp_k, vecs[v].exp_win, $sformatf("vec%0d", v));
        end

        // in_last and start together: start is dropped, tile waits in LOADED
        fill_tile(2);
        load_tile(4, 1'b1, 4, 1'b1, "coinc");
        tick();
        tick();
        check("coinc.hold", 128'({busy, in_ready, dbg_state}), 128'({1'b0, 1'b0, LOADED}));
        stream_tile(4, 4 + N - 1, "coinc");

        for (int r = 0; r < 6; r++) begin
            k        = $urandom_range(1, K_MAX);
            use_last = 1'($urandom_range(0, 1));
            if (use_last) begin
                n_drive = k;
                exp_k   = k;
            end else begin
                n_drive = K_MAX + $urandom_range(0, 1);
                exp_k   = K_MAX;
            end
            fill_tile(2);
            load_tile(n_drive, use_last, exp_k, 1'b0, $sformatf("rnd%0d", r));
            stream_tile(exp_k, exp_k + N - 1, $sformatf("rnd%0d", r));
        end

        // reset two cycles into a stream aborts it without done
        fill_tile(2);
        load_tile(5, 1'b1, 5, 1'b0, "abort");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort.t2", out_word(), model_word(1, 5, 5 + N - 1));
        rst_n = 1'b0;
        #1;
        check("abort.async", out_word(), 128'(0));
        check("abort.ready", 128'(in_ready), 128'(0));
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_done = seen_done | done;
        end
        #3 rst_n = 1'b1;
        tick();
        seen_done = seen_done | done;
        check("abort.no_done", 128'(seen_done), 128'(0));
        check("abort.release", 128'({in_ready, dbg_state}), 128'({1'b1, LOAD}));
        exp_perf = 0;

        fill_tile(0);
        load_tile(3, 1'b1, 3, 1'b0, "recover");
        stream_tile(3, 6, "recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
